// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hack_pkg
// Brief   : Shared widths, Hack jump encodings and the jump-condition helper.
// Revision: 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    typedef logic [WIDTH_DEFAULT-1:0] pc_t;

    // zr=ng=1 is illegal upstream; it is evaluated as-is with no special case
    function automatic logic jump_taken(input logic [2:0] jump,
                                        input logic       zr,
                                        input logic       ng);
        logic pos;
        pos = ~zr & ~ng;
        return (jump[2] & ng) | (jump[1] & zr) | (jump[0] & pos);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_pc_if.sv
`default_nettype none
// ============================================================================
// Module  : hack_pc_if
// Brief   : Control/address bundle between the Hack sequencer and the PC stage.
// Revision: 1.0 - initial release
// ============================================================================
interface hack_pc_if #(
    parameter int WIDTH = hack_pkg::WIDTH_DEFAULT
);
    logic [WIDTH-1:0] in_i;
    logic [2:0]       jump_i;
    logic             zr_i;
    logic             ng_i;
    logic             inc_i;
    logic             stall_i;
    logic [WIDTH-1:0] out_o;
    logic             taken_o;
    logic             wrap_o;
    logic             halt_o;

    modport master (
        output in_i, jump_i, zr_i, ng_i, inc_i, stall_i,
        input  out_o, taken_o, wrap_o, halt_o
    );

    modport slave (
        input  in_i, jump_i, zr_i, ng_i, inc_i, stall_i,
        output out_o, taken_o, wrap_o, halt_o
    );
endinterface
`default_nettype wire

// File: rtl/inc16.sv
`default_nettype none
// ============================================================================
// Module  : inc16
// Brief   : Combinational +1 adder core (modulo 2^WIDTH).
// Revision: 1.0 - initial release
// ============================================================================
module inc16 #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0] in_i,
    output logic      [WIDTH-1:0] out_o
);

    assign out_o = in_i + WIDTH'(1);

endmodule
`default_nettype wire

// File: rtl/hack_pc.sv
`default_nettype none
// ============================================================================
// Module  : hack_pc
// Brief   : Hack program counter with jump decode, stall and self-jump halt.
// Revision: 1.0 - initial release
// ============================================================================
module hack_pc
    import hack_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int HALT_CYCLES = 2
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    hack_pc_if.slave    bus
);

    localparam logic [3:0] c_halt_cycles = 4'(HALT_CYCLES);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             wrap_q, wrap_d;
    logic             halt_q, halt_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] w_pc_inc;
    logic             w_take;
    logic             w_self_jump;

    inc16 #(.WIDTH(WIDTH)) u_inc (
        .in_i  (pc_q),
        .out_o (w_pc_inc)
    );

    assign w_take      = jump_taken(bus.jump_i, bus.zr_i, bus.ng_i);
    assign w_self_jump = w_take && (bus.in_i == pc_q);

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        if (!bus.stall_i) begin
            if (w_take) begin
                pc_d    = bus.in_i;
                taken_d = 1'b1;
            end else if (bus.inc_i) begin
                pc_d   = w_pc_inc;
                wrap_d = &pc_q;
            end
            // Only back-to-back self-jumps count; anything else restarts the run
            if (w_self_jump) begin
                cnt_d = (cnt_q == c_halt_cycles) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd0;
            end
            if (cnt_d == c_halt_cycles) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
            wrap_q  <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            wrap_q  <= wrap_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_o   = pc_q;
    assign bus.taken_o = taken_q;
    assign bus.wrap_o  = wrap_q;
    assign bus.halt_o  = halt_q;

endmodule
`default_nettype wire
